// File: rtl/formula_nested_sqrt_fsm.sv
// Nested integer square root sequencer: res = isqrt(t0 + isqrt(t1 + ... + isqrt(t[N-1]))).
// Drives one external isqrt unit and waits on its valid strobe, so the root latency can be anything.
module formula_nested_sqrt_fsm #(
   parameter int N_TERMS = 3,
   parameter int WIDTH   = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_arg_vld,
   output logic                       o_arg_rdy,
   input  logic [N_TERMS*WIDTH-1:0]   i_args,
   output logic                       o_res_vld,
   output logic [WIDTH-1:0]           o_res,
   output logic                       o_isqrt_x_vld,
   output logic [WIDTH-1:0]           o_isqrt_x,
   input  logic                       i_isqrt_y_vld,
   input  logic [WIDTH/2-1:0]         i_isqrt_y
);

   localparam int IDX_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t             r_state;
   state_t             w_stateNext;
   logic [WIDTH-1:0]   r_terms [N_TERMS];
   logic [IDX_W-1:0]   r_idx;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_res;
   logic               w_accept;
   logic               w_yGood;
   logic [WIDTH-1:0]   w_yExt;
   logic [WIDTH-1:0]   w_sum;

   assign w_accept = i_arg_vld && o_arg_rdy;
   assign w_yGood  = (r_state == WAIT) && i_isqrt_y_vld;
   assign w_yExt   = {{(WIDTH/2){1'b0}}, i_isqrt_y};
   // Sum wraps modulo 2^WIDTH on purpose.
   assign w_sum    = r_terms[r_idx] + r_acc;
   assign o_res    = r_res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_stateNext = ISSUE;
         ISSUE:   w_stateNext = WAIT;
         WAIT:    if (i_isqrt_y_vld) w_stateNext = (r_idx == '0) ? DONE : ISSUE;
         DONE:    w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // Ready is gated by reset so the source sees no acceptance window while reset is held.
   always_comb begin
      o_arg_rdy     = rst_n && (r_state == IDLE);
      o_res_vld     = (r_state == DONE);
      o_isqrt_x_vld = (r_state == ISSUE);
      o_isqrt_x     = (r_state == ISSUE) ? w_sum : '0;
   end

   // The last root goes straight into r_res so it is already valid during DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
         r_acc <= '0;
         r_res <= '0;
         for (int i = 0; i < N_TERMS; i++) begin
            r_terms[i] <= '0;
         end
      end else begin
         if (w_accept) begin
            for (int i = 0; i < N_TERMS; i++) begin
               r_terms[i] <= i_args[i*WIDTH +: WIDTH];
            end
            r_idx <= IDX_W'(N_TERMS - 1);
            r_acc <= '0;
         end
         if (w_yGood) begin
            r_acc <= w_yExt;
            if (r_idx == '0) begin
               r_res <= w_yExt;
            end else begin
               r_idx <= r_idx - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_formula_nested_sqrt_fsm.sv
// Directed bench for formula_nested_sqrt_fsm with behavioural isqrt units of programmable latency.
// Covers a 3-term instance (table vectors plus multi-cycle corner sequences) and a 1-term instance.
module tb_formula_nested_sqrt_fsm;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          argVld;
   logic          argRdy;
   logic [95:0]   args;
   logic          resVld;
   logic [31:0]   res;
   logic          xVld;
   logic [31:0]   x;
   logic          yVldDut;
   logic [15:0]   yDut;
   logic          spurVld;
   int            lat;

   logic          argVld1;
   logic          argRdy1;
   logic [31:0]   args1;
   logic          resVld1;
   logic [31:0]   res1;
   logic          xVld1;
   logic [31:0]   x1;
   logic          yVld1;
   logic [15:0]   y1;

   int            vecCount = 0;
   int            missCount = 0;
   int            resCount = 0;
   logic [31:0]   issuedQ [$];

   formula_nested_sqrt_fsm #(.N_TERMS(3), .WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_arg_vld(argVld), .o_arg_rdy(argRdy), .i_args(args),
      .o_res_vld(resVld), .o_res(res),
      .o_isqrt_x_vld(xVld), .o_isqrt_x(x),
      .i_isqrt_y_vld(yVldDut), .i_isqrt_y(yDut)
   );

   formula_nested_sqrt_fsm #(.N_TERMS(1), .WIDTH(32)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .i_arg_vld(argVld1), .o_arg_rdy(argRdy1), .i_args(args1),
      .o_res_vld(resVld1), .o_res(res1),
      .o_isqrt_x_vld(xVld1), .o_isqrt_x(x1),
      .i_isqrt_y_vld(yVld1), .i_isqrt_y(y1)
   );

   function automatic logic [15:0] isqrtF(input logic [31:0] v);
      logic [15:0] r;
      logic [31:0] t;
      r = '0;
      for (int b = 15; b >= 0; b--) begin
         t = {16'd0, r | (16'd1 << b)};
         if (t * t <= v) r = t[15:0];
      end
      return r;
   endfunction

   function automatic logic [31:0] nestedF(input logic [95:0] a);
      logic [31:0] acc;
      logic [31:0] s;
      acc = '0;
      for (int i = 2; i >= 0; i--) begin
         s   = a[i*32 +: 32] + acc;
         acc = {16'd0, isqrtF(s)};
      end
      return acc;
   endfunction

   // Behavioural isqrt for the 3-term instance: result valid lat cycles after the request cycle.
   logic          mVld;
   logic [15:0]   mY;
   logic          mBusy;
   int            mCnt;
   logic [31:0]   mX;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mVld <= 1'b0; mY <= '0; mBusy <= 1'b0; mCnt <= 0; mX <= '0;
      end else begin
         mVld <= 1'b0;
         if (xVld) begin
            if (lat <= 1) begin
               mVld <= 1'b1; mY <= isqrtF(x);
            end else begin
               mBusy <= 1'b1; mCnt <= lat - 1; mX <= x;
            end
         end else if (mBusy) begin
            if (mCnt == 1) begin
               mVld <= 1'b1; mY <= isqrtF(mX); mBusy <= 1'b0;
            end else begin
               mCnt <= mCnt - 1;
            end
         end
      end
   end
   assign yVldDut = mVld | spurVld;
   assign yDut    = spurVld ? 16'hBEEF : mY;

   // Fixed latency-3 isqrt for the 1-term instance.
   logic          nBusy;
   int            nCnt;
   logic [31:0]   nX;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         yVld1 <= 1'b0; y1 <= '0; nBusy <= 1'b0; nCnt <= 0; nX <= '0;
      end else begin
         yVld1 <= 1'b0;
         if (xVld1) begin
            nBusy <= 1'b1; nCnt <= 2; nX <= x1;
         end else if (nBusy) begin
            if (nCnt == 1) begin
               yVld1 <= 1'b1; y1 <= isqrtF(nX); nBusy <= 1'b0;
            end else begin
               nCnt <= nCnt - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (resVld) resCount++;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Offers one bundle, then returns the cycle (relative to acceptance) of res_vld, or -1 on timeout.
   task automatic applyStimulus(input logic [95:0] a, output int cycles, output logic [31:0] gotRes);
      issuedQ.delete();
      cycles = -1;
      gotRes = '0;
      @(negedge clk);
      args   = a;
      argVld = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         if (n == 1) argVld = 1'b0;
         if (xVld) issuedQ.push_back(x);
         if (resVld) begin
            cycles = n;
            gotRes = res;
            break;
         end
      end
   endtask

   typedef struct {
      logic [31:0] t0, t1, t2;
      logic [31:0] i0, i1, i2;
      logic [31:0] expRes;
   } vec_t;

   vec_t          vecs [6];
   int            cyc;
   logic [31:0]   got;
   int            rcBefore;
   logic [95:0]   bundle;
   logic [31:0]   expR;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'd0,  32'd0,          32'd16,         32'd16,         32'd4,     32'd2,   32'd1};
      vecs[1] = '{32'd12, 32'd7,          32'd81,         32'd81,         32'd16,    32'd16,  32'd4};
      vecs[2] = '{32'd1,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd65534, 32'd256, 32'd16};
      vecs[3] = '{32'd5,  32'd3,          32'd100,        32'd100,        32'd13,    32'd8,   32'd2};
      vecs[4] = '{32'd0,  32'd0,          32'd0,          32'd0,          32'd0,     32'd0,   32'd0};
      vecs[5] = '{32'd99, 32'd0,          32'd1,          32'd1,          32'd1,     32'd100, 32'd10};

      argVld = 1'b0; args = '0; spurVld = 1'b0; lat = 4;
      argVld1 = 1'b0; args1 = '0;

      #2;
      checkOutput("reset_arg_rdy",   {31'd0, argRdy}, 32'd0);
      checkOutput("reset_res_vld",   {31'd0, resVld}, 32'd0);
      checkOutput("reset_res",       res, 32'd0);
      checkOutput("reset_x_vld",     {31'd0, xVld}, 32'd0);
      checkOutput("reset_x",         x, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle_arg_rdy", {31'd0, argRdy}, 32'd1);

      // Table vectors with fixed latency 4.
      for (int v = 0; v < 6; v++) begin
         applyStimulus({vecs[v].t2, vecs[v].t1, vecs[v].t0}, cyc, got);
         checkOutput($sformatf("v%0d_res", v), got, vecs[v].expRes);
         checkOutput($sformatf("v%0d_latency", v), cyc, 32'd16);
         checkOutput($sformatf("v%0d_nreq", v), issuedQ.size(), 32'd3);
         if (issuedQ.size() == 3) begin
            checkOutput($sformatf("v%0d_req0", v), issuedQ[0], vecs[v].i0);
            checkOutput($sformatf("v%0d_req1", v), issuedQ[1], vecs[v].i1);
            checkOutput($sformatf("v%0d_req2", v), issuedQ[2], vecs[v].i2);
         end
         @(negedge clk);
         checkOutput($sformatf("v%0d_rdy_back", v), {31'd0, argRdy}, 32'd1);
         repeat (3) @(negedge clk);
         checkOutput($sformatf("v%0d_res_hold", v), res, vecs[v].expRes);
      end

      // arg_vld held high through a busy period with a different bundle.
      rcBefore = resCount;
      @(negedge clk);
      args = {32'd16, 32'd0, 32'd0};
      argVld = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) args = {32'd81, 32'd7, 32'd12};
         if (n == 3)  checkOutput("busy_rdy_c3",  {31'd0, argRdy}, 32'd0);
         if (n == 10) checkOutput("busy_rdy_c10", {31'd0, argRdy}, 32'd0);
         if (n == 16) begin
            checkOutput("busy_first_vld", {31'd0, resVld}, 32'd1);
            checkOutput("busy_first_res", res, 32'd1);
         end
         if (n == 17) begin
            checkOutput("busy_rdy_c17", {31'd0, argRdy}, 32'd1);
            checkOutput("busy_xvld_c17", {31'd0, xVld}, 32'd0);
         end
         if (n == 18) begin
            checkOutput("busy_second_req", x, 32'd81);
            checkOutput("busy_second_xvld", {31'd0, xVld}, 32'd1);
            argVld = 1'b0;
         end
         if (n == 33) begin
            checkOutput("busy_second_vld", {31'd0, resVld}, 32'd1);
            checkOutput("busy_second_res", res, 32'd4);
         end
      end
      #1;
      checkOutput("busy_result_count", resCount - rcBefore, 32'd2);

      // Random isqrt latency with a spurious y_vld pulse while idle.
      rcBefore = resCount;
      for (int it = 0; it < 8; it++) begin
         lat = $urandom_range(1, 20);
         bundle = {$urandom, $urandom, 32'($urandom_range(0, 1000))};
         expR = nestedF(bundle);
         @(negedge clk);
         spurVld = 1'b1;
         @(negedge clk);
         spurVld = 1'b0;
         applyStimulus(bundle, cyc, got);
         checkOutput($sformatf("rand%0d_res", it), got, expR);
         checkOutput($sformatf("rand%0d_latency", it), cyc, 32'(3 * (lat + 1) + 1));
      end
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rand_result_count", resCount - rcBefore, 32'd8);

      // Reset asserted during the wait for term 1.
      lat = 4;
      @(negedge clk);
      args = {32'd81, 32'd7, 32'd12};
      argVld = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (n == 1) argVld = 1'b0;
      end
      rcBefore = resCount;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_arg_rdy", {31'd0, argRdy}, 32'd0);
      checkOutput("mid_rst_res_vld", {31'd0, resVld}, 32'd0);
      checkOutput("mid_rst_x_vld",   {31'd0, xVld}, 32'd0);
      checkOutput("mid_rst_x",       x, 32'd0);
      checkOutput("mid_rst_res",     res, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      checkOutput("mid_rst_no_result", resCount - rcBefore, 32'd0);
      applyStimulus({32'd16, 32'd0, 32'd0}, cyc, got);
      checkOutput("post_rst_res", got, 32'd1);
      checkOutput("post_rst_latency", cyc, 32'd16);

      // Single-term instance, isqrt latency 3: res_vld at 1*(3+1)+1.
      for (int k = 0; k < 2; k++) begin
         cyc = -1;
         got = '0;
         @(negedge clk);
         args1 = (k == 0) ? 32'd1000 : 32'hFFFF_FFFF;
         argVld1 = 1'b1;
         for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) argVld1 = 1'b0;
            if (resVld1) begin
               cyc = n;
               got = res1;
               break;
            end
         end
         checkOutput($sformatf("n1_%0d_res", k), got, (k == 0) ? 32'd31 : 32'd65535);
         checkOutput($sformatf("n1_%0d_latency", k), cyc, 32'd5);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
